// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word types, MIPS opcode/funct encodings and
// scoreboard sizing.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;
    typedef logic [1:0]  sb_count_t;

    localparam int NUM_REGS        = 32;
    localparam int SB_MAX_INFLIGHT = 3;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0a,
        OP_SLTIU = 6'h0b,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2a,
        FN_SLTU = 6'h2b
    } funct_t;

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one register: one increment, three decrement strobes.
// Out-of-range results hold the current count and raise err_o for that cycle.
module sb_counter
    import cpu_types_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      inc_i,
    input  logic      dec_wb_i,
    input  logic      dec_ex_i,
    input  logic      dec_mem_i,
    output sb_count_t count_o,
    output logic      err_o
);

    sb_count_t         count_q, count_d;
    logic signed [2:0] sum;

    always_comb begin
        sum = $signed({1'b0, count_q})
            + $signed({2'b00, inc_i})
            - $signed({2'b00, dec_wb_i})
            - $signed({2'b00, dec_ex_i})
            - $signed({2'b00, dec_mem_i});
        // Reachable range is -3..+4; +4 wraps to -4, so the sign bit flags
        // both overflow and underflow.
        err_o   = sum[2];
        count_d = err_o ? count_q : sb_count_t'(sum[1:0]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register pending counts, RAW stall generation,
// in-flight total and a sticky protocol-error flag.
module reg_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter bit WB_BYPASS    = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       issue_valid,
    input  logic       issue_regwr,
    input  regbits_t   issue_wsel,
    input  regbits_t   id_rs,
    input  regbits_t   id_rt,
    input  logic       id_use_rt,
    input  logic       wb_valid,
    input  regbits_t   wb_wsel,
    input  logic       sq_ex_valid,
    input  logic       sq_mem_valid,
    input  regbits_t   sq_ex_wsel,
    input  regbits_t   sq_mem_wsel,
    output logic       stall,
    output logic       busy_rs,
    output logic       busy_rt,
    output logic [1:0] inflight,
    output logic       sb_empty,
    output logic       sb_err
);

    localparam logic signed [3:0] MAX_S = 4'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0][1:0] cnt;
    logic [NUM_REGS-1:1]      cnt_err;
    logic                     accept, dec_wb, dec_ex, dec_mem;
    logic [1:0]               inflight_q, inflight_d;
    logic signed [3:0]        inflight_sum;
    logic                     inflight_err;
    logic                     err_q, err_d;

    // $0 is hardwired, so it never has a pending write.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter u_cnt (
            .clk_i     (CLK),
            .rst_ni    (nRST),
            .inc_i     (accept       && (issue_wsel  == regbits_t'(r))),
            .dec_wb_i  (wb_valid     && (wb_wsel     == regbits_t'(r))),
            .dec_ex_i  (sq_ex_valid  && (sq_ex_wsel  == regbits_t'(r))),
            .dec_mem_i (sq_mem_valid && (sq_mem_wsel == regbits_t'(r))),
            .count_o   (cnt[r]),
            .err_o     (cnt_err[r])
        );
    end

    function automatic logic operand_busy(input sb_count_t c, input regbits_t sel,
                                          input logic wbv, input regbits_t wbs);
        // A last pending write retiring this cycle is forwarded, so no hazard.
        return (c != '0) && !(WB_BYPASS && (c == 2'd1) && wbv && (wbs == sel));
    endfunction

    always_comb begin
        busy_rs = operand_busy(cnt[id_rs], id_rs, wb_valid, wb_wsel);
        busy_rt = id_use_rt && operand_busy(cnt[id_rt], id_rt, wb_valid, wb_wsel);
        stall   = busy_rs || busy_rt;
    end

    assign accept  = issue_valid && issue_regwr && !stall && (issue_wsel != '0);
    assign dec_wb  = wb_valid     && (wb_wsel     != '0);
    assign dec_ex  = sq_ex_valid  && (sq_ex_wsel  != '0);
    assign dec_mem = sq_mem_valid && (sq_mem_wsel != '0);

    always_comb begin
        inflight_sum = $signed({2'b00, inflight_q})
                     + $signed({3'b000, accept})
                     - $signed({3'b000, dec_wb})
                     - $signed({3'b000, dec_ex})
                     - $signed({3'b000, dec_mem});
        inflight_err = 1'b0;
        inflight_d   = inflight_sum[1:0];
        if (inflight_sum > MAX_S) begin
            inflight_err = 1'b1;
            inflight_d   = MAX_S[1:0];
        end else if (inflight_sum < 4'sd0) begin
            inflight_err = 1'b1;
            inflight_d   = 2'd0;
        end
        err_d = err_q || inflight_err || (|cnt_err) || (issue_valid && stall);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign inflight = inflight_q;
    assign sb_empty = (inflight_q == 2'd0);
    assign sb_err   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: a per-cycle vector table plus hand-written
// sequences for error stickiness, reset and saturation.
module tb_reg_scoreboard;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       issue_valid, issue_regwr, id_use_rt, wb_valid, sq_ex_valid, sq_mem_valid;
    regbits_t   issue_wsel, id_rs, id_rt, wb_wsel, sq_ex_wsel, sq_mem_wsel;
    logic       stall, busy_rs, busy_rt, sb_empty, sb_err;
    logic [1:0] inflight;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_scoreboard #(.MAX_INFLIGHT(3), .WB_BYPASS(1'b1)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .issue_valid  (issue_valid),
        .issue_regwr  (issue_regwr),
        .issue_wsel   (issue_wsel),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rt    (id_use_rt),
        .wb_valid     (wb_valid),
        .wb_wsel      (wb_wsel),
        .sq_ex_valid  (sq_ex_valid),
        .sq_mem_valid (sq_mem_valid),
        .sq_ex_wsel   (sq_ex_wsel),
        .sq_mem_wsel  (sq_mem_wsel),
        .stall        (stall),
        .busy_rs      (busy_rs),
        .busy_rt      (busy_rt),
        .inflight     (inflight),
        .sb_empty     (sb_empty),
        .sb_err       (sb_err)
    );

    // One row per clock cycle; exp = {stall, busy_rs, busy_rt, inflight[1:0], sb_empty, sb_err}
    // observed during that cycle, before the edge commits it.
    typedef struct {
        string      name;
        logic       iv;
        logic [4:0] iws;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       wbv;
        logic [4:0] wbs;
        logic       sev;
        logic [4:0] ses;
        logic       smv;
        logic [4:0] sms;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Negative register arguments mean "strobe not asserted".
    task automatic add(input string n, input int iss, input int rs, input int rt,
                       input logic use_rt, input int wb, input int se, input int sm,
                       input logic [6:0] e);
        vec_t v;
        v.name   = n;
        v.iv     = (iss >= 0);
        v.iws    = (iss >= 0) ? 5'(iss) : 5'd0;
        v.rs     = 5'(rs);
        v.rt     = 5'(rt);
        v.use_rt = use_rt;
        v.wbv    = (wb >= 0);
        v.wbs    = (wb >= 0) ? 5'(wb) : 5'd0;
        v.sev    = (se >= 0);
        v.ses    = (se >= 0) ? 5'(se) : 5'd0;
        v.smv    = (sm >= 0);
        v.sms    = (sm >= 0) ? 5'(sm) : 5'd0;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [6:0] got, input logic [6:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", n, got, exp);
        end
    endtask

    function automatic logic [6:0] obs();
        return {stall, busy_rs, busy_rt, inflight, sb_empty, sb_err};
    endfunction

    task automatic idle_in();
        nRST         = 1'b1;
        issue_valid  = 1'b0;
        issue_regwr  = 1'b0;
        issue_wsel   = '0;
        id_rs        = '0;
        id_rt        = '0;
        id_use_rt    = 1'b0;
        wb_valid     = 1'b0;
        wb_wsel      = '0;
        sq_ex_valid  = 1'b0;
        sq_ex_wsel   = '0;
        sq_mem_valid = 1'b0;
        sq_mem_wsel  = '0;
    endtask

    task automatic next();
        @(negedge CLK);
        idle_in();
    endtask

    task automatic issue(input int r);
        issue_valid = 1'b1;
        issue_regwr = 1'b1;
        issue_wsel  = 5'(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //   name             iss  rs  rt use  wb  se  sm   exp
        add("reset_state",    -1,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue3",          3,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("raw_rs3",        -1,  3,  0, 0,  -1, -1, -1, 7'b110_01_00);
        add("rt3_unused",     -1,  1,  3, 0,  -1, -1, -1, 7'b000_01_00);
        add("raw_rt3",        -1,  1,  3, 1,  -1, -1, -1, 7'b101_01_00);
        add("wb_bypass3",     -1,  3,  0, 0,   3, -1, -1, 7'b000_01_00);
        add("after_wb3",      -1,  3,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue5a",         5,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue6",          6,  0,  0, 0,  -1, -1, -1, 7'b000_01_00);
        add("issue5b",         5,  0,  0, 0,  -1, -1, -1, 7'b000_10_00);
        add("squash_ex_mem",  -1,  5,  0, 0,  -1,  5,  6, 7'b110_11_00);
        add("post_squash",    -1,  6,  5, 1,  -1, -1, -1, 7'b101_01_00);
        add("wb5_last",       -1,  5,  0, 0,   5, -1, -1, 7'b000_01_00);
        add("drained5",       -1,  5,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue9",          9,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue_wb9",       9,  0,  0, 0,   9, -1, -1, 7'b000_01_00);
        add("net_zero9",      -1,  9,  0, 0,  -1, -1, -1, 7'b110_01_00);
        add("wb9",            -1,  9,  0, 0,   9, -1, -1, 7'b000_01_00);
        add("drained9",       -1,  9,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue_r0",        0,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("read_r0",        -1,  0,  0, 1,  -1, -1, -1, 7'b000_00_10);
        add("issue13a",       13,  0,  0, 0,  -1, -1, -1, 7'b000_00_10);
        add("issue13b",       13,  0,  0, 0,  -1, -1, -1, 7'b000_01_00);
        add("issue13c",       13,  0,  0, 0,  -1, -1, -1, 7'b000_10_00);
        add("triple_dec13",   -1, 13,  0, 0,  13, 13, 13, 7'b110_11_00);
        add("drained13",      -1, 13,  0, 0,  -1, -1, -1, 7'b000_00_10);

        idle_in();
        nRST = 1'b0;
        next(); nRST = 1'b0;
        next(); nRST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            idle_in();
            issue_valid  = vecs[i].iv;
            issue_regwr  = vecs[i].iv;
            issue_wsel   = vecs[i].iws;
            id_rs        = vecs[i].rs;
            id_rt        = vecs[i].rt;
            id_use_rt    = vecs[i].use_rt;
            wb_valid     = vecs[i].wbv;
            wb_wsel      = vecs[i].wbs;
            sq_ex_valid  = vecs[i].sev;
            sq_ex_wsel   = vecs[i].ses;
            sq_mem_valid = vecs[i].smv;
            sq_mem_wsel  = vecs[i].sms;
            #1;
            check(vecs[i].name, obs(), vecs[i].exp);
        end

        // Issue attempted while stalled: not counted, error raised.
        next(); issue(4);
        next(); id_rs = 5'd4; issue(8);
        #1;
        check("stalled_issue_stall", 7'(stall), 7'd1);
        next(); id_rs = 5'd8;
        #1;
        check("stalled_issue_r8_idle", 7'(busy_rs), 7'd0);
        check("stalled_issue_inflight", 7'(inflight), 7'd1);
        check("stalled_issue_err", 7'(sb_err), 7'd1);
        next(); nRST = 1'b0;
        next(); id_rs = 5'd4;
        #1;
        check("reset_clears_all", obs(), 7'b000_00_10);

        // Writeback with nothing pending: sticky error until reset.
        next(); wb_valid = 1'b1; wb_wsel = 5'd7;
        next();
        #1;
        check("underflow_err", 7'(sb_err), 7'd1);
        check("underflow_inflight_sat", 7'(inflight), 7'd0);
        for (int k = 0; k < 10; k++) begin
            next();
            #1;
            check($sformatf("err_sticky_%0d", k), 7'(sb_err), 7'd1);
        end
        next(); nRST = 1'b0;
        next();
        #1;
        check("err_cleared_by_reset", 7'(sb_err), 7'd0);

        // Reset in the middle of traffic discards everything, including that cycle's inputs.
        next(); issue(10);
        next(); issue(11);
        next(); nRST = 1'b0; issue(12); wb_valid = 1'b1; wb_wsel = 5'd10;
        next(); id_rs = 5'd10; id_rt = 5'd12; id_use_rt = 1'b1;
        #1;
        check("midop_reset", obs(), 7'b000_00_10);

        // Fourth outstanding write to one register: counter and inflight saturate.
        next(); issue(13);
        next(); issue(13);
        next(); issue(13);
        next(); issue(13);
        #1;
        check("overflow_pre", obs(), 7'b000_11_00);
        next(); id_rs = 5'd13;
        #1;
        check("overflow_post", obs(), 7'b110_11_01);
        next(); id_rs = 5'd13; wb_valid = 1'b1; wb_wsel = 5'd13;
        next(); id_rs = 5'd13;
        #1;
        check("overflow_count_held3", 7'(busy_rs), 7'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  MAX_INFLIGHT, 3, maximum simultaneous outstanding register writes (EX, MEM, WB).
  WB_BYPASS, 1, 1 = a same-cycle writeback clears the busy indication in that cycle.
REQ-002 Ports, one per line: name, direction, width, meaning.
  CLK  in  1  clock; all state updates on rising edge.
  nRST  in  1  reset; synchronous, active-low.
  issue_valid  in  1  ID instruction advances into EX this cycle.
  issue_regwr  in  1  issuing instruction writes a register.
  issue_wsel  in  5 (regbits_t)  destination register of issuing instruction.
  id_rs, id_rt  in  5 each  source registers of the instruction in ID.
  id_use_rt  in  1  ID instruction reads rt (R-type, SW, BEQ/BNE).
  wb_valid  in  1  WB instruction retires its register write this cycle.
  wb_wsel  in  5  writeback destination.
  sq_ex_valid, sq_mem_valid  in  1 each  EX/MEM instruction squashed this cycle (jump/JR flush).
  sq_ex_wsel, sq_mem_wsel  in  5 each  destination of the squashed instruction.
  stall  out  1  ID must hold; PC enable must be deasserted.
  busy_rs, busy_rt  out  1 each  per-operand pending-write indication.
  inflight  out  2  total outstanding writes.
  sb_empty  out  1  no outstanding writes.
  sb_err  out  1  sticky protocol error.

Function
REQ-003 The block SHALL hold one 2-bit pending counter per register 1..31; register 0 SHALL never be tracked, and busy for register 0 SHALL always be 0.
REQ-004 An issue SHALL be accepted when issue_valid=1, issue_regwr=1, stall=0 and issue_wsel!=0; acceptance SHALL increment that register's counter and inflight at the next edge.
REQ-005 wb_valid=1 with wb_wsel!=0 SHALL decrement that counter and inflight; each asserted squash input with nonzero wsel SHALL likewise decrement.
REQ-006 Per-register next count SHALL be count + inc - (number of matching decrements), computed in 3-bit signed arithmetic, so that 1 increment and up to 3 decrements to the same register in one cycle resolve correctly.
REQ-007 A result above 3, or below 0, SHALL leave the counter unchanged for that register, clamp it to the range 0..3, and set sb_err.
REQ-008 inflight exceeding MAX_INFLIGHT, or decrementing below 0, SHALL set sb_err and saturate the count.
REQ-009 busy_rs SHALL be 1 when count[id_rs]!=0; when WB_BYPASS=1, busy_rs SHALL be 0 if count[id_rs]=1 and wb_valid=1 with wb_wsel=id_rs. busy_rt follows the same rule, gated by id_use_rt.
REQ-010 stall SHALL equal busy_rs OR busy_rt, and is combinational from registered state and the current inputs.
REQ-011 issue_valid=1 while stall=1 SHALL not be counted and SHALL set sb_err.
REQ-012 sb_empty SHALL equal (inflight==0); sb_err SHALL remain set until reset.
REQ-013 Issue and writeback of the same register in the same cycle SHALL leave the count unchanged (net 0).

Reset
REQ-014 On a rising CLK edge with nRST=0, all counters, inflight and sb_err SHALL clear to 0; inputs are ignored during that cycle.
REQ-015 Immediately after reset, outputs SHALL be stall=0, busy_rs=busy_rt=0, inflight=0, sb_empty=1 and sb_err=0.
REQ-016 Reset asserted mid-operation SHALL discard all pending state, with no partial update.

Structure
REQ-017 regbits_t, word_t and opcode/funct enums SHALL come from cpu_types_pkg; a scoreboard count type (2-bit) and MAX_INFLIGHT default SHALL be added there.
REQ-018 One sub-module, sb_counter (a single per-register counter with increment, 3 decrement strobes, clamp and error output), SHALL be instantiated 31 times by a generate loop.

Verification
REQ-019 Issue ADD to $3; next cycle, id_rs=3 -> stall=1, busy_rs=1, inflight=1.
REQ-020 Issue to $3, then wb_valid with wb_wsel=3 while id_rs=3 and WB_BYPASS=1 -> stall=0 in that cycle; inflight=0 and sb_empty=1 the next cycle.
REQ-021 Issue to $5, then $6, then $5 (3 in flight); squash the EX ($5) and MEM ($6) entries in the same cycle -> count[5]=1, count[6]=0, inflight=1, sb_err=0.
REQ-022 Issue with issue_wsel=0, then id_rs=0 -> no count change, stall=0.
REQ-023 Writeback to $7 with count 0 -> sb_err=1, sticky across 10 idle cycles; nRST=0 for one cycle -> sb_err=0.
REQ-024 Hold issue_valid=1 during stall=1 -> inflight unchanged, sb_err=1.
